aes_inv_cntx: RTL and testbench
===============================

Name: aes_inv_cntx

Overview:
- Control sequencer for the AES-128 inverse cipher (decryption). It is the decrypt-direction counterpart of the encryption round controller.
- It runs a forward key expansion to obtain the last round key, then steps the inverse rounds from NR-1 down to 0 with inverse key-schedule steps.
- It drives the decrypt datapath (state/key registers, inverse round logic) and reports status to the testbench/host.
- It caches the last round key so that repeat decryptions under the same key skip the expansion phase.

Parameters:
- NR, 10, number of rounds; also sets the width of completed_round.
- ROUND_CYCLES, 4, cycles per inverse round; must be 2 or more.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  request decryption; honoured only while accept=1.
- key_same  in  1  sampled with start; 1 means the key is unchanged since the last cold run.
- accept  out  1  idle and ready for start.
- load_key  out  1  one-cycle pulse that loads the cipher key into the key-schedule register.
- restore_lrk  out  1  one-cycle pulse that reloads the key register from the cached last-round-key register.
- save_lrk  out  1  one-cycle pulse that copies the key register into the last-round-key register.
- enb_ks  out  1  key-schedule step enable.
- ks_inv  out  1  key-schedule direction: 0 forward, 1 inverse.
- rnd_no  out  4  current round index.
- init_ark  out  1  initial AddRoundKey with rk[NR]; first inverse-round cycle only.
- last_rnd  out  1  high throughout round 0, telling the datapath to skip InvMixColumns.
- done  out  1  result valid; held until the next accepted start or reset.
- completed_round  out  NR  one-hot indicator of the inverse round in progress.

Behaviour:
- Outputs are registered. Reset values: accept=1, done=0, rnd_no=0, completed_round=0, every pulse output 0, ks_inv=0, internal key_cached=0. States are IDLE, LOAD, KEYEXP, ROUND, FIN.
- IDLE: accept=1. On start=1 at clock edge E0:
  - accept<=0, done<=0, completed_round<=0.
  - Warm path: if key_same=1 and key_cached=1, go to LOAD with restore_lrk=1.
  - Cold path: otherwise go to LOAD with load_key=1 and clear key_cached.
- Timing below counts cycles after E0, with cycle 1 being the LOAD cycle.
- KEYEXP (cold path only): cycles 2..NR+1. enb_ks=1, ks_inv=0, rnd_no=1..NR in turn.
- ROUND: starts at cycle R0, where R0=NR+2 on the cold path and R0=2 on the warm path. Inverse round i (i=0..NR-1) occupies cycles R0+i*ROUND_CYCLES through R0+(i+1)*ROUND_CYCLES-1.
  - rnd_no=NR-1-i and completed_round=1<<i for the whole round.
  - enb_ks=1 and ks_inv=1 on the first cycle of every round only.
  - init_ark=1 on the first cycle of round i=0 only.
  - save_lrk=1 on the same cycle as init_ark, cold path only. key_cached<=1 at that cycle's edge.
  - last_rnd=1 while rnd_no=0.
- FIN: cycle R0+NR*ROUND_CYCLES. done=1, accept=1, rnd_no=0, completed_round=0. Return to IDLE.
- Latency from E0 to done: cold NR+2+NR*ROUND_CYCLES (52 at defaults); warm 2+NR*ROUND_CYCLES (42 at defaults).
- start while accept=0 is ignored. start deasserting mid-run does not pause or abort the run.
- rstn=0 at any cycle returns every output and key_cached to reset values at the next edge. The next run is cold.
- start together with key_same=1 but key_cached=0 takes the cold path.
- The cycle counter wraps at ROUND_CYCLES-1 exactly. The round counter stops after rnd_no=0; there is no underflow.
- enb_ks is never high on two consecutive cycles during ROUND. ks_inv is only 1 while in ROUND.

Decomposition:
- Shared package aes_pkg holds the NR and ROUND_CYCLES defaults, the state enum (IDLE, LOAD, KEYEXP, ROUND, FIN) and the round-index width.
- No sub-module: a single FSM plus a cycle counter and a round counter.

Test Plan:
- Cold run at defaults: reset, then start=1, key_same=0 → load_key at cycle 1. enb_ks high with ks_inv=0 for cycles 2..11, rnd_no 1..10. Cycle 12: init_ark, save_lrk and enb_ks/ks_inv together, rnd_no=9. done=1 at cycle 52.
- Warm rerun: after a cold run, start=1, key_same=1 → restore_lrk at cycle 1, no KEYEXP, rnd_no=9 at cycle 2, no save_lrk, done at cycle 42.
- Round sequencing: during the run check completed_round goes 0x001..0x200, each held exactly 4 cycles. rnd_no goes 9..0. last_rnd is high only for cycles 48..51 (cold). Exactly 10 inverse enb_ks pulses.
- start pulses while busy (cycles 5 and 30) → ignored. done still arrives at cycle 52 and accept stays 0 until then.
- Reset at cycle 20 → every output returns to its reset value next cycle. A following start with key_same=1 takes the cold path (load_key=1).
- Parameter sweep NR=10, ROUND_CYCLES=2 → cold done at cycle 32, warm done at cycle 22.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared defaults, state encoding and round-index width for the AES inverse sequencer
package aes_pkg;
  localparam int NR_DEF = 10;
  localparam int ROUND_CYCLES_DEF = 4;
  localparam int RW = 4;
  typedef enum logic [2:0] {IDLE, LOAD, KEYEXP, ROUND, FIN} state_t;
endpackage

// File: rtl/aes_inv_cntx.sv
// aes_inv_cntx: AES-128 inverse-cipher sequencer; ports: clk/rstn, start/key_same in; accept, key-register pulses, ks controls, rnd_no, init_ark, last_rnd, done, completed_round out
module aes_inv_cntx
  import aes_pkg::*;
#(
  parameter int NR = NR_DEF,
  parameter int ROUND_CYCLES = ROUND_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          key_same,
  output logic          accept,
  output logic          load_key,
  output logic          restore_lrk,
  output logic          save_lrk,
  output logic          enb_ks,
  output logic          ks_inv,
  output logic [RW-1:0] rnd_no,
  output logic          init_ark,
  output logic          last_rnd,
  output logic          done,
  output logic [NR-1:0] completed_round
);
  localparam int CW = $clog2(ROUND_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(ROUND_CYCLES - 1);
  localparam logic [RW-1:0] KEXP_LAST = RW'(NR);
  localparam logic [RW-1:0] RND_FIRST = RW'(NR - 1);
  state_t state, nstate;
  logic [CW-1:0] cyc, cyc_n;
  logic cold, cold_n, key_cached, kc_n;
  logic accept_n, load_n, restore_n, save_n, enb_n, ks_inv_n, init_n, last_n, done_n;
  logic [RW-1:0] rnd_n;
  logic [NR-1:0] cr_n;
  logic start_ok, warm, enter, step;
  assign start_ok = start && accept;
  assign warm = key_same && key_cached;
  assign enter = nstate == ROUND && state != ROUND;
  assign step = state == ROUND && cyc == CYC_LAST && rnd_no != '0;
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      cyc <= '0;
      cold <= 1'b0;
      key_cached <= 1'b0;
      accept <= 1'b1;
      load_key <= 1'b0;
      restore_lrk <= 1'b0;
      save_lrk <= 1'b0;
      enb_ks <= 1'b0;
      ks_inv <= 1'b0;
      init_ark <= 1'b0;
      last_rnd <= 1'b0;
      done <= 1'b0;
      rnd_no <= '0;
      completed_round <= '0;
    end else begin
      state <= nstate;
      cyc <= cyc_n;
      cold <= cold_n;
      key_cached <= kc_n;
      accept <= accept_n;
      load_key <= load_n;
      restore_lrk <= restore_n;
      save_lrk <= save_n;
      enb_ks <= enb_n;
      ks_inv <= ks_inv_n;
      init_ark <= init_n;
      last_rnd <= last_n;
      done <= done_n;
      rnd_no <= rnd_n;
      completed_round <= cr_n;
    end
  always_comb begin
    nstate = state;
    case (state)
      IDLE, FIN: nstate = start_ok ? LOAD : IDLE;
      LOAD:      nstate = cold ? KEYEXP : ROUND;
      KEYEXP:    nstate = rnd_no == KEXP_LAST ? ROUND : KEYEXP;
      ROUND:     nstate = cyc == CYC_LAST && rnd_no == '0 ? FIN : ROUND;
      default:   nstate = IDLE;
    endcase
  end
  // Cached key becomes valid once save_lrk has actually copied it.
  always_comb begin
    accept_n = accept;
    done_n = done;
    rnd_n = rnd_no;
    cr_n = completed_round;
    last_n = last_rnd;
    cyc_n = cyc;
    cold_n = cold;
    kc_n = key_cached | save_lrk;
    load_n = 1'b0;
    restore_n = 1'b0;
    save_n = 1'b0;
    enb_n = 1'b0;
    ks_inv_n = 1'b0;
    init_n = 1'b0;
    if (start_ok) begin
      accept_n = 1'b0;
      done_n = 1'b0;
      cr_n = '0;
      restore_n = warm;
      load_n = !warm;
      cold_n = !warm;
      kc_n = warm;
    end
    if (nstate == KEYEXP) begin
      enb_n = 1'b1;
      rnd_n = state == LOAD ? RW'(1) : rnd_no + RW'(1);
    end
    if (state == ROUND) cyc_n = cyc == CYC_LAST ? '0 : cyc + CW'(1);
    if (enter || step) begin
      enb_n = 1'b1;
      ks_inv_n = 1'b1;
      rnd_n = enter ? RND_FIRST : rnd_no - RW'(1);
      cr_n = enter ? NR'(1) : completed_round << 1;
      last_n = rnd_n == '0;
    end
    if (enter) begin
      init_n = 1'b1;
      save_n = cold;
      cyc_n = '0;
    end
    if (nstate == FIN) begin
      done_n = 1'b1;
      accept_n = 1'b1;
      rnd_n = '0;
      cr_n = '0;
      last_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_inv_cntx.sv
// tb_aes_inv_cntx: directed cycle-by-cycle check of the AES inverse sequencer at RC=4 and RC=2
module tb_aes_inv_cntx;
  localparam int NR = 10;
  localparam int RC = 4;
  logic clk = 1'b0;
  logic rstn, start, key_same;
  logic accept, load_key, restore_lrk, save_lrk, enb_ks, ks_inv, init_ark, last_rnd, done;
  logic [3:0] rnd_no;
  logic [NR-1:0] completed_round;
  logic s_rstn, s_start, s_key_same;
  logic s_accept, s_load_key, s_restore_lrk, s_save_lrk, s_enb_ks, s_ks_inv, s_init_ark, s_last_rnd, s_done;
  logic [3:0] s_rnd_no;
  logic [NR-1:0] s_completed_round;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  aes_inv_cntx #(.NR(NR), .ROUND_CYCLES(RC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .key_same(key_same), .accept(accept),
    .load_key(load_key), .restore_lrk(restore_lrk), .save_lrk(save_lrk), .enb_ks(enb_ks),
    .ks_inv(ks_inv), .rnd_no(rnd_no), .init_ark(init_ark), .last_rnd(last_rnd), .done(done),
    .completed_round(completed_round)
  );
  aes_inv_cntx #(.NR(NR), .ROUND_CYCLES(2)) dut_s (
    .clk(clk), .rstn(s_rstn), .start(s_start), .key_same(s_key_same), .accept(s_accept),
    .load_key(s_load_key), .restore_lrk(s_restore_lrk), .save_lrk(s_save_lrk), .enb_ks(s_enb_ks),
    .ks_inv(s_ks_inv), .rnd_no(s_rnd_no), .init_ark(s_init_ark), .last_rnd(s_last_rnd), .done(s_done),
    .completed_round(s_completed_round)
  );
  localparam logic [22:0] RST_VEC = 23'h400000;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [22:0] obs();
    return {accept, load_key, restore_lrk, save_lrk, enb_ks, ks_inv, init_ark, last_rnd, done, rnd_no, completed_round};
  endfunction
  function automatic logic [22:0] expv(input bit cold, input int k);
    int r0, fin, i, ph;
    logic a, l, r, s, e, ki, ia, lr, d;
    logic [3:0] rn;
    logic [NR-1:0] cr;
    {a, l, r, s, e, ki, ia, lr, d} = '0;
    rn = '0;
    cr = '0;
    r0 = cold ? NR + 2 : 2;
    fin = r0 + NR * RC;
    if (k == 1) begin
      l = cold;
      r = !cold;
    end else if (cold && k <= NR + 1) begin
      e = 1'b1;
      rn = 4'(k - 1);
    end else if (k < fin) begin
      i = (k - r0) / RC;
      ph = (k - r0) % RC;
      rn = 4'(NR - 1 - i);
      cr = NR'(1) << i;
      e = ph == 0;
      ki = e;
      ia = e && i == 0;
      s = ia && cold;
      lr = rn == 0;
    end else begin
      a = 1'b1;
      d = 1'b1;
    end
    return {a, l, r, s, e, ki, ia, lr, d, rn, cr};
  endfunction
  task automatic run(input string nm, input bit ks, input bit cold, input int busy_a, input int busy_b, input int rst_at);
    int fin, pulses;
    fin = (cold ? NR + 2 : 2) + NR * RC;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    key_same = ks;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, k), 32'(obs()), 32'(expv(cold, k)));
      pulses += int'(enb_ks && ks_inv);
      start = k == busy_a || k == busy_b;
      if (k == rst_at) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk({nm, "_rst"}, 32'(obs()), 32'(RST_VEC));
        return;
      end
    end
    start = 1'b0;
    chk({nm, "_inv_pulses"}, pulses, NR);
    @(negedge clk);
    chk({nm, "_done_hold"}, {done, accept}, 2'b11);
  endtask
  task automatic run_s(input string nm, input bit ks, input int exp_lat);
    int lat;
    @(negedge clk);
    s_start = 1'b1;
    s_key_same = ks;
    @(negedge clk);
    s_start = 1'b0;
    chk({nm, "_path"}, {s_load_key, s_restore_lrk}, ks ? 2'b01 : 2'b10);
    lat = 1;
    while (!s_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
  endtask
  initial begin
    rstn = 1'b0;
    start = 1'b0;
    key_same = 1'b0;
    s_rstn = 1'b0;
    s_start = 1'b0;
    s_key_same = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", 32'(obs()), 32'(RST_VEC));
    rstn = 1'b1;
    s_rstn = 1'b1;
    run("cold", 1'b0, 1'b1, 5, 30, 0);
    run("warm", 1'b1, 1'b0, 0, 0, 0);
    run("abort", 1'b0, 1'b1, 0, 0, 20);
    run("post_rst", 1'b1, 1'b1, 0, 0, 0);
    run("warm2", 1'b1, 1'b0, 0, 0, 0);
    run_s("sw_cold", 1'b0, 32);
    run_s("sw_warm", 1'b1, 22);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
